// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - shared widths, frame constants and loader states
package fabric_cfg_pkg;
  localparam int SRAM_W = 144;
  localparam int CB_W   = 420;
  localparam int SB_W   = 240;
  localparam int TOTAL  = SRAM_W + CB_W + SB_W;
  localparam int NBYTES = (TOTAL + 7) / 8;
  localparam int SHW    = NBYTES * 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;
endpackage

// File: rtl/cfg_shadow_reg.sv
// rtl/cfg_shadow_reg.sv - payload shift register with running XOR checksum
module cfg_shadow_reg
  import fabric_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [7:0]       din,
  output logic [TOTAL-1:0] cfg_bits,
  output logic [7:0]       chk
);
  logic [SHW-1:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      chk    <= '0;
    end else if (clear) begin
      shadow <= '0;
      chk    <= '0;
    end else if (shift) begin
      shadow <= {shadow[SHW-9:0], din};
      chk    <= chk ^ din;
    end
  end

  // Low pad bits of the final byte fall off the bottom.
  assign cfg_bits = shadow[SHW-1 -: TOTAL];
endmodule

// File: rtl/fabric_cfg_loader.sv
// rtl/fabric_cfg_loader.sv - framed byte loader committing fabric configuration atomically
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cfg_valid,
  output logic [SRAM_W-1:0] sramConfig,
  output logic [CB_W-1:0]   cbconfig,
  output logic [SB_W-1:0]   sconfig
);
  state_t           state, state_next;
  logic [6:0]       count;
  logic             xfer, sh_clear, sh_shift, commit, err_set;
  logic [7:0]       chk;
  logic [TOTAL-1:0] cfg_bits;

  assign xfer = din_valid && din_ready;

  cfg_shadow_reg u_shadow (
    .clk      (clk),
    .reset    (reset),
    .clear    (sh_clear),
    .shift    (sh_shift),
    .din      (din),
    .cfg_bits (cfg_bits),
    .chk      (chk)
  );

  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    busy       = 1'b0;
    sh_clear   = 1'b0;
    sh_shift   = 1'b0;
    commit     = 1'b0;
    err_set    = 1'b0;
    case (state)
      HUNT: begin
        din_ready = 1'b1;
        if (xfer && din == SYNC_BYTE) begin
          state_next = PAYLOAD;
          sh_clear   = 1'b1;
        end
      end
      PAYLOAD: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (xfer) begin
          sh_shift = 1'b1;
          if (count == 7'(NBYTES - 1)) state_next = CHECK;
        end
      end
      CHECK: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (xfer) begin
          if (din == chk) begin
            state_next = COMMIT;
          end else begin
            state_next = HUNT;
            err_set    = 1'b1;
          end
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
    // Abort wins over any same-cycle transfer, but a commit already underway finishes.
    if (abort && state != COMMIT) begin
      state_next = HUNT;
      sh_shift   = 1'b0;
      sh_clear   = 1'b1;
      err_set    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cfg_valid  <= 1'b0;
      sramConfig <= '0;
      cbconfig   <= '0;
      sconfig    <= '0;
    end else begin
      state <= state_next;
      done  <= commit;
      err   <= err_set;
      if (sh_clear)      count <= '0;
      else if (sh_shift) count <= count + 7'd1;
      if (commit) begin
        sramConfig <= cfg_bits[TOTAL-1 -: SRAM_W];
        cbconfig   <= cfg_bits[TOTAL-SRAM_W-1 -: CB_W];
        sconfig    <= cfg_bits[SB_W-1:0];
        cfg_valid  <= 1'b1;
      end
    end
  end
endmodule
